// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator core: operation codes, control FSM
// states, and the {mode,key} press decoder.
package rpn_pkg;

  typedef enum logic [4:0] {
    OP_NONE,
    OP_PUSH, OP_POP,  OP_SWAP, OP_DUP,
    OP_ADD,  OP_SUB,  OP_MUL,  OP_AND,
    OP_OR,   OP_XOR,  OP_SHL,  OP_SHR,
    OP_CLR,  OP_NEG,  OP_MIN,  OP_MAX
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    WRITE
  } state_e;

  // Only a single low key selects an operation; idle or multi-low patterns yield OP_NONE.
  function automatic op_e decode(input logic [1:0] mode, input logic [3:0] key);
    logic [1:0] k;
    logic       vld;
    op_e        op;
    k   = 2'd0;
    vld = 1'b1;
    op  = OP_NONE;
    case (key)
      4'b1110: k = 2'd0;
      4'b1101: k = 2'd1;
      4'b1011: k = 2'd2;
      4'b0111: k = 2'd3;
      default: vld = 1'b0;
    endcase
    if (vld) begin
      case ({mode, k})
        4'h0: op = OP_PUSH;
        4'h1: op = OP_POP;
        4'h2: op = OP_SWAP;
        4'h3: op = OP_DUP;
        4'h4: op = OP_ADD;
        4'h5: op = OP_SUB;
        4'h6: op = OP_MUL;
        4'h7: op = OP_AND;
        4'h8: op = OP_OR;
        4'h9: op = OP_XOR;
        4'hA: op = OP_SHL;
        4'hB: op = OP_SHR;
        4'hC: op = OP_CLR;
        4'hD: op = OP_NEG;
        4'hE: op = OP_MIN;
        default: op = OP_MAX;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/rpn_stack_core_if.sv
// Board-facing bundle of the RPN core: operator inputs (mode/key/val) and
// the stack/status view consumed by the display drivers.
interface rpn_stack_core_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 8
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [1:0]       mode;
  logic [3:0]       key;
  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [CNTW-1:0]  count;
  logic [CW-1:0]    counter;
  logic             err;
  logic             busy;

  modport master (
    output mode, key, val,
    input  top, next, count, counter, err, busy
  );

  modport slave (
    input  mode, key, val,
    output top, next, count, counter, err, busy
  );
endinterface

// File: rtl/rpn_mul.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH
// iterations, keeps only the low WIDTH bits of the product.
module rpn_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);
  localparam int ITW = $clog2(WIDTH + 1);
  localparam logic [ITW-1:0] ITER_C = ITW'(WIDTH);
  localparam logic [ITW-1:0] ONE_C  = ITW'(1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [ITW-1:0]   it_q, it_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    it_d     = it_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      it_d     = ITER_C;
    end else if (it_q != '0) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      it_d     = it_q - ONE_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      it_q     <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      it_q     <= it_d;
    end
  end

  // High during the cycle whose closing edge performs the final iteration.
  assign done_o = (it_q == ONE_C);
  assign prod_o = acc_q;

endmodule

// File: rtl/rpn_stack_core.sv
// RPN calculator core: shift-register operand stack with press-edge key
// detection, sticky error flag and a multi-cycle multiply.
module rpn_stack_core
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  rpn_stack_core_if.slave bus
);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int SHW  = $clog2(WIDTH);
  localparam logic [CNTW-1:0] FULL_C = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] TWO_C  = CNTW'(2);
  localparam logic [CNTW-1:0] ONE_C  = CNTW'(1);
  localparam logic [CW-1:0]   CINC_C = CW'(1);

  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]    ctr_q, ctr_d;
  logic             err_q, err_d;
  logic [3:0]       key_q;
  state_e           state_q;
  logic             busy_q;

  logic             shift_up, shift_dn, wr_top, fault, exec, mul_start, mul_done;
  logic [WIDTH-1:0] top_val, mul_prod;
  op_e              op;

  function automatic logic [WIDTH-1:0] alu(input op_e f, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (f)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[SHW-1:0];
      OP_SHR:  return a >> b[SHW-1:0];
      OP_MIN:  return (a < b) ? a : b;
      OP_MAX:  return (a > b) ? a : b;
      default: return '0;
    endcase
  endfunction

  // A press only counts on the first edge after idle, and never while multiplying.
  assign op = (state_q == IDLE && key_q == 4'hF) ? decode(bus.mode, bus.key) : OP_NONE;

  always_comb begin
    stk_d     = stk_q;
    cnt_d     = cnt_q;
    ctr_d     = ctr_q;
    err_d     = err_q;
    shift_up  = 1'b0;
    shift_dn  = 1'b0;
    wr_top    = 1'b0;
    top_val   = '0;
    fault     = 1'b0;
    exec      = 1'b0;
    mul_start = 1'b0;
    if (state_q == WRITE) begin
      shift_up = 1'b1;
      wr_top   = 1'b1;
      top_val  = mul_prod;
      cnt_d    = cnt_q - ONE_C;
      exec     = 1'b1;
    end else begin
      case (op)
        OP_NONE: ;
        OP_PUSH: begin
          if (cnt_q == FULL_C) fault = 1'b1;
          else begin
            shift_dn = 1'b1; wr_top = 1'b1; top_val = bus.val;
            cnt_d = cnt_q + ONE_C; exec = 1'b1;
          end
        end
        OP_DUP: begin
          if (cnt_q == '0 || cnt_q == FULL_C) fault = 1'b1;
          else begin
            shift_dn = 1'b1; wr_top = 1'b1; top_val = stk_q[0];
            cnt_d = cnt_q + ONE_C; exec = 1'b1;
          end
        end
        OP_POP: begin
          if (cnt_q == '0) fault = 1'b1;
          else begin
            shift_up = 1'b1; cnt_d = cnt_q - ONE_C; exec = 1'b1;
          end
        end
        OP_SWAP: begin
          if (cnt_q < TWO_C) fault = 1'b1;
          else begin
            stk_d[0] = stk_q[1]; stk_d[1] = stk_q[0]; exec = 1'b1;
          end
        end
        OP_NEG: begin
          if (cnt_q == '0) fault = 1'b1;
          else begin
            wr_top = 1'b1; top_val = '0 - stk_q[0]; exec = 1'b1;
          end
        end
        OP_MUL: begin
          if (cnt_q < TWO_C) fault = 1'b1;
          else mul_start = 1'b1;
        end
        OP_CLR: begin
          for (int i = 0; i < DEPTH; i++) stk_d[i] = '0;
          cnt_d = '0;
          err_d = 1'b0;
          exec  = 1'b1;
        end
        default: begin
          if (cnt_q < TWO_C) fault = 1'b1;
          else begin
            shift_up = 1'b1; wr_top = 1'b1; top_val = alu(op, stk_q[1], stk_q[0]);
            cnt_d = cnt_q - ONE_C; exec = 1'b1;
          end
        end
      endcase
    end
    if (shift_up) begin
      for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
      stk_d[DEPTH-1] = '0;
    end
    if (shift_dn) begin
      for (int i = 1; i < DEPTH; i++) stk_d[i] = stk_q[i-1];
    end
    if (wr_top) stk_d[0] = top_val;
    if (fault)  err_d = 1'b1;
    if (exec)   ctr_d = ctr_q + CINC_C;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      cnt_q <= '0;
      ctr_q <= '0;
      err_q <= 1'b0;
      key_q <= 4'hF;
    end else begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= stk_d[i];
      cnt_q <= cnt_d;
      ctr_q <= ctr_d;
      err_q <= err_d;
      key_q <= bus.key;
    end
  end

  // busy covers the detect edge through the WRITE edge that commits the product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mul_start) begin
          state_q <= MUL;
          busy_q  <= 1'b1;
        end
        MUL: if (mul_done) state_q <= WRITE;
        WRITE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  rpn_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst),
    .start_i (mul_start),
    .a_i     (stk_q[1]),
    .b_i     (stk_q[0]),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  assign bus.top     = (cnt_q != '0)    ? stk_q[0] : '0;
  assign bus.next    = (cnt_q >= TWO_C) ? stk_q[1] : '0;
  assign bus.count   = cnt_q;
  assign bus.counter = ctr_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_rpn_stack_core.sv
// Directed bench for rpn_stack_core (WIDTH=16, DEPTH=8, CW=8).
module tb_rpn_stack_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_ctr = 8'd0;

  rpn_stack_core_if #(.WIDTH(16), .DEPTH(8), .CW(8)) bus ();

  rpn_stack_core #(.WIDTH(16), .DEPTH(8), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic press(input logic [1:0] m, input logic [3:0] k, input logic [15:0] v,
                       input bit ex);
    @(negedge clk);
    bus.mode = m; bus.key = k; bus.val = v;
    @(negedge clk);
    bus.key = 4'hF;
    if (ex) exp_ctr++;
  endtask

  task automatic run_mul(input bit inject, output int nbusy,
                         output logic [15:0] mid_top, output logic [15:0] mid_next);
    nbusy = 0; mid_top = 16'hxxxx; mid_next = 16'hxxxx;
    @(negedge clk);
    bus.mode = 2'd1; bus.key = 4'b1011;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      nbusy++;
      if (i == 2) begin mid_top = bus.top; mid_next = bus.next; end
      if (i == 0) bus.key = 4'hF;
      if (inject && i == 2) begin bus.mode = 2'd0; bus.key = 4'b1101; end
      if (i == 3) bus.key = 4'hF;
    end
    bus.key = 4'hF;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.mode = 2'd0; bus.key = 4'hF; bus.val = 16'h0;
    #3;
    checks++; if (bus.top !== 16'h0) begin fails++; $display("FAIL reset_top: got %h want 0000", bus.top); end
    checks++; if (bus.next !== 16'h0) begin fails++; $display("FAIL reset_next: got %h want 0000", bus.next); end
    checks++; if (bus.count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.counter !== 8'd0) begin fails++; $display("FAIL reset_counter: got %0d want 0", bus.counter); end
    checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL reset_flags: got err=%b busy=%b want 0 0", bus.err, bus.busy); end
    @(negedge clk); rst = 1'b1;
    exp_ctr = 8'd0;
  endtask

  task automatic test_add();
    press(2'd0, 4'b1110, 16'h0005, 1);
    press(2'd0, 4'b1110, 16'h0003, 1);
    press(2'd1, 4'b1110, 16'h0000, 1);
    checks++; if (bus.top !== 16'h0008) begin fails++; $display("FAIL add_top: got %h want 0008", bus.top); end
    checks++; if (bus.next !== 16'h0000) begin fails++; $display("FAIL add_next: got %h want 0000", bus.next); end
    checks++; if (bus.count !== 4'd1) begin fails++; $display("FAIL add_count: got %0d want 1", bus.count); end
    checks++; if (bus.counter !== 8'd3) begin fails++; $display("FAIL add_counter: got %0d want 3", bus.counter); end
    checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL add_err: got %b want 0", bus.err); end
  endtask

  task automatic test_wrap_hold();
    press(2'd0, 4'b1110, 16'hFFFF, 1);
    press(2'd0, 4'b1110, 16'h0002, 1);
    press(2'd1, 4'b1110, 16'h0000, 1);
    checks++; if (bus.top !== 16'h0001) begin fails++; $display("FAIL wrap_top: got %h want 0001", bus.top); end
    checks++; if (bus.next !== 16'h0008 || bus.count !== 4'd2) begin fails++; $display("FAIL wrap_stack: got next=%h count=%0d want 0008 2", bus.next, bus.count); end
    @(negedge clk);
    bus.mode = 2'd0; bus.key = 4'b1110; bus.val = 16'h0011;
    repeat (5) @(negedge clk);
    bus.key = 4'hF;
    exp_ctr++;
    checks++; if (bus.count !== 4'd3 || bus.top !== 16'h0011) begin fails++; $display("FAIL hold_once: got count=%0d top=%h want 3 0011", bus.count, bus.top); end
    checks++; if (bus.counter !== 8'd7) begin fails++; $display("FAIL hold_counter: got %0d want 7", bus.counter); end
  endtask

  task automatic test_mul();
    int nb;
    logic [15:0] mt, mn;
    press(2'd3, 4'b1110, 16'h0, 1);
    press(2'd0, 4'b1110, 16'h0007, 1);
    press(2'd0, 4'b1110, 16'h0006, 1);
    run_mul(1'b1, nb, mt, mn);
    exp_ctr++;
    checks++; if (nb !== 17) begin fails++; $display("FAIL mul_busy_cycles: got %0d want 17", nb); end
    checks++; if (mt !== 16'h0006 || mn !== 16'h0007) begin fails++; $display("FAIL mul_hold: got top=%h next=%h want 0006 0007", mt, mn); end
    checks++; if (bus.top !== 16'h002A || bus.count !== 4'd1) begin fails++; $display("FAIL mul_result: got top=%h count=%0d want 002a 1", bus.top, bus.count); end
    checks++; if (bus.counter !== exp_ctr || bus.busy !== 1'b0) begin fails++; $display("FAIL mul_counter: got %0d busy=%b want %0d 0", bus.counter, bus.busy, exp_ctr); end
    press(2'd0, 4'b1110, 16'h0300, 1);
    press(2'd0, 4'b1110, 16'h0101, 1);
    run_mul(1'b0, nb, mt, mn);
    exp_ctr++;
    checks++; if (bus.top !== 16'h0300 || bus.next !== 16'h002A) begin fails++; $display("FAIL mul_wrap: got top=%h next=%h want 0300 002a", bus.top, bus.next); end
    checks++; if (bus.count !== 4'd2 || bus.counter !== exp_ctr) begin fails++; $display("FAIL mul_wrap_state: got count=%0d counter=%0d want 2 %0d", bus.count, bus.counter, exp_ctr); end
  endtask

  task automatic test_ops();
    press(2'd3, 4'b1110, 16'h0, 1);
    press(2'd0, 4'b1110, 16'h00F0, 1);
    press(2'd0, 4'b1110, 16'h0014, 1);
    press(2'd2, 4'b1011, 16'h0, 1);
    checks++; if (bus.top !== 16'h0F00) begin fails++; $display("FAIL shl: got %h want 0f00", bus.top); end
    press(2'd0, 4'b1110, 16'h0003, 1);
    press(2'd2, 4'b0111, 16'h0, 1);
    checks++; if (bus.top !== 16'h01E0) begin fails++; $display("FAIL shr: got %h want 01e0", bus.top); end
    press(2'd0, 4'b1110, 16'h0F0F, 1);
    press(2'd2, 4'b1101, 16'h0, 1);
    checks++; if (bus.top !== 16'h0EEF) begin fails++; $display("FAIL xor: got %h want 0eef", bus.top); end
    press(2'd3, 4'b1101, 16'h0, 1);
    checks++; if (bus.top !== 16'hF111 || bus.count !== 4'd1) begin fails++; $display("FAIL neg: got %h count=%0d want f111 1", bus.top, bus.count); end
    press(2'd0, 4'b1110, 16'h1000, 1);
    press(2'd3, 4'b1011, 16'h0, 1);
    checks++; if (bus.top !== 16'h1000 || bus.count !== 4'd1) begin fails++; $display("FAIL min: got %h count=%0d want 1000 1", bus.top, bus.count); end
    press(2'd0, 4'b0111, 16'h0, 1);
    checks++; if (bus.next !== 16'h1000 || bus.count !== 4'd2) begin fails++; $display("FAIL dup: got next=%h count=%0d want 1000 2", bus.next, bus.count); end
    press(2'd0, 4'b1110, 16'h00FF, 1);
    press(2'd3, 4'b0111, 16'h0, 1);
    checks++; if (bus.top !== 16'h1000 || bus.count !== 4'd2) begin fails++; $display("FAIL max: got %h count=%0d want 1000 2", bus.top, bus.count); end
    press(2'd1, 4'b1101, 16'h0, 1);
    press(2'd0, 4'b1110, 16'h0005, 1);
    press(2'd1, 4'b1101, 16'h0, 1);
    checks++; if (bus.top !== 16'hFFFB || bus.count !== 4'd1) begin fails++; $display("FAIL sub: got %h count=%0d want fffb 1", bus.top, bus.count); end
    press(2'd0, 4'b1110, 16'h0F0F, 1);
    press(2'd1, 4'b0111, 16'h0, 1);
    checks++; if (bus.top !== 16'h0F0B) begin fails++; $display("FAIL and: got %h want 0f0b", bus.top); end
    press(2'd0, 4'b1110, 16'h00F0, 1);
    press(2'd2, 4'b1110, 16'h0, 1);
    checks++; if (bus.top !== 16'h0FFB) begin fails++; $display("FAIL or: got %h want 0ffb", bus.top); end
    press(2'd0, 4'b1110, 16'h0001, 1);
    press(2'd0, 4'b1011, 16'h0, 1);
    checks++; if (bus.top !== 16'h0FFB || bus.next !== 16'h0001) begin fails++; $display("FAIL swap: got top=%h next=%h want 0ffb 0001", bus.top, bus.next); end
    checks++; if (bus.counter !== exp_ctr || bus.err !== 1'b0) begin fails++; $display("FAIL ops_counter: got %0d err=%b want %0d 0", bus.counter, bus.err, exp_ctr); end
  endtask

  task automatic test_underflow();
    press(2'd3, 4'b1110, 16'h0, 1);
    press(2'd1, 4'b1101, 16'h0, 0);
    checks++; if (bus.err !== 1'b1 || bus.count !== 4'd0) begin fails++; $display("FAIL uf_sub: got err=%b count=%0d want 1 0", bus.err, bus.count); end
    checks++; if (bus.counter !== exp_ctr) begin fails++; $display("FAIL uf_counter: got %0d want %0d", bus.counter, exp_ctr); end
    press(2'd0, 4'b1010, 16'h0055, 0);
    checks++; if (bus.count !== 4'd0 || bus.counter !== exp_ctr || bus.top !== 16'h0) begin fails++; $display("FAIL multi_low: got count=%0d counter=%0d top=%h want 0 %0d 0000", bus.count, bus.counter, bus.top, exp_ctr); end
    press(2'd3, 4'b1110, 16'h0, 1);
    checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL clear_err: got %b want 0", bus.err); end
    press(2'd0, 4'b1110, 16'h0009, 1);
    press(2'd0, 4'b1011, 16'h0, 0);
    checks++; if (bus.err !== 1'b1 || bus.top !== 16'h0009 || bus.count !== 4'd1) begin fails++; $display("FAIL uf_swap: got err=%b top=%h count=%0d want 1 0009 1", bus.err, bus.top, bus.count); end
    press(2'd3, 4'b1110, 16'h0, 1);
    press(2'd0, 4'b1110, 16'h0009, 1);
    press(2'd1, 4'b1011, 16'h0, 0);
    checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.counter !== exp_ctr) begin fails++; $display("FAIL uf_mul: got err=%b busy=%b counter=%0d want 1 0 %0d", bus.err, bus.busy, bus.counter, exp_ctr); end
    press(2'd3, 4'b1110, 16'h0, 1);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) press(2'd0, 4'b1110, 16'(i * 16'h0011), 1);
    checks++; if (bus.count !== 4'd8 || bus.err !== 1'b0) begin fails++; $display("FAIL of_fill: got count=%0d err=%b want 8 0", bus.count, bus.err); end
    press(2'd0, 4'b1110, 16'h0099, 0);
    checks++; if (bus.count !== 4'd8 || bus.err !== 1'b1 || bus.top !== 16'h0088) begin fails++; $display("FAIL of_push: got count=%0d err=%b top=%h want 8 1 0088", bus.count, bus.err, bus.top); end
    press(2'd0, 4'b0111, 16'h0, 0);
    checks++; if (bus.count !== 4'd8 || bus.counter !== exp_ctr) begin fails++; $display("FAIL of_dup: got count=%0d counter=%0d want 8 %0d", bus.count, bus.counter, exp_ctr); end
    press(2'd0, 4'b1101, 16'h0, 1);
    checks++; if (bus.count !== 4'd7 || bus.top !== 16'h0077 || bus.err !== 1'b1) begin fails++; $display("FAIL err_sticky_pop: got count=%0d top=%h err=%b want 7 0077 1", bus.count, bus.top, bus.err); end
    press(2'd3, 4'b1110, 16'h0, 1);
    checks++; if (bus.count !== 4'd0 || bus.err !== 1'b0 || bus.top !== 16'h0) begin fails++; $display("FAIL of_clear: got count=%0d err=%b top=%h want 0 0 0000", bus.count, bus.err, bus.top); end
  endtask

  task automatic test_counter_wrap();
    for (int i = 0; i < 256 && exp_ctr != 8'hFF; i++) press(2'd3, 4'b1110, 16'h0, 1);
    checks++; if (bus.counter !== 8'hFF) begin fails++; $display("FAIL ctr_max: got %0d want 255", bus.counter); end
    press(2'd3, 4'b1110, 16'h0, 1);
    checks++; if (bus.counter !== 8'h00) begin fails++; $display("FAIL ctr_wrap: got %0d want 0", bus.counter); end
  endtask

  task automatic test_reset_mid_mul();
    press(2'd0, 4'b1110, 16'h0003, 1);
    press(2'd0, 4'b1110, 16'h0004, 1);
    @(negedge clk);
    bus.mode = 2'd1; bus.key = 4'b1011;
    repeat (5) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rmul_busy: got %b want 1", bus.busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin fails++; $display("FAIL rmul_flags: got busy=%b err=%b want 0 0", bus.busy, bus.err); end
    checks++; if (bus.top !== 16'h0 || bus.next !== 16'h0) begin fails++; $display("FAIL rmul_stack: got top=%h next=%h want 0000 0000", bus.top, bus.next); end
    checks++; if (bus.count !== 4'd0 || bus.counter !== 8'd0) begin fails++; $display("FAIL rmul_counts: got count=%0d counter=%0d want 0 0", bus.count, bus.counter); end
    @(negedge clk);
    bus.key = 4'hF; rst = 1'b1;
    exp_ctr = 8'd0;
    repeat (20) @(negedge clk);
    checks++; if (bus.count !== 4'd0 || bus.busy !== 1'b0) begin fails++; $display("FAIL rmul_no_resume: got count=%0d busy=%b want 0 0", bus.count, bus.busy); end
    press(2'd0, 4'b1110, 16'h0009, 1);
    checks++; if (bus.top !== 16'h0009 || bus.count !== 4'd1 || bus.counter !== 8'd1) begin fails++; $display("FAIL rmul_after: got top=%h count=%0d counter=%0d want 0009 1 1", bus.top, bus.count, bus.counter); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap_hold();
    test_mul();
    test_ops();
    test_underflow();
    test_overflow();
    test_counter_wrap();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
